// File: rtl/credit_return_buffer_pkg.sv
// Shared width helpers for the credit return buffer slice.
// Counters covering 0..DEPTH need $clog2(DEPTH+1) bits; pointers covering
// 0..DEPTH-1 need $clog2(DEPTH) bits, but never fewer than one.
package credit_return_buffer_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwft_ram_fifo.sv
// First-word fall-through FIFO built on a plain register array.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i, data_i write request and data (ignored when full)
//   pop_i          read request (ignored when empty)
//   data_o         head entry, forced to zero while empty
//   empty_o/full_o occupancy flags
//   count_o        stored entries
module fwft_ram_fifo
  import credit_return_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned CNT_W     = cnt_width(DEPTH),
  localparam int unsigned PTR_W     = ptr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  // Wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count;

  // Storage is not reset; the head is masked so outputs read zero when empty.
  assign data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/credit_return_buffer.sv
// Consumer end of a fixed-latency, non-stallable pipeline. Upstream may launch
// only while every in-flight item is guaranteed a buffer slot; results are
// captured on arrival and presented in order on a valid/ready interface.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   issue_req_i / issue_ok_o  launch request / launch permitted this cycle
//   pipe_valid_i, pipe_data_i result arriving from the pipeline
//   valid_o, data_o, ready_i  in-order output (first-word fall-through)
//   count_o                   stored entries
//   inflight_o                launched, not yet arrived
//   err_o                     sticky protocol error
module credit_return_buffer
  import credit_return_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned PIPE_LATENCY = 4,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned CNT_W       = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_req_i,
  output logic                  issue_ok_o,
  input  logic                  pipe_valid_i,
  input  logic [DATA_WIDTH-1:0] pipe_data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [CNT_W-1:0]      inflight_o,
  output logic                  err_o
);

  if (PIPE_LATENCY < 1 || DEPTH < 1) begin : g_bad_params
    $error("credit_return_buffer: PIPE_LATENCY and DEPTH must be >= 1");
  end

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_nxt;
  logic [CNT_W:0]   occupancy_nxt;
  logic             issue_ok_q;
  logic             err_q;
  logic             fire;
  logic             accept;
  logic             spurious;
  logic             overflow;
  logic             push_ok;
  logic             pop;
  logic             empty;
  logic             full;

  assign fire     = issue_req_i & issue_ok_q;
  assign accept   = pipe_valid_i & (inflight != '0);
  assign spurious = pipe_valid_i & (inflight == '0);
  assign overflow = accept & full;
  assign push_ok  = accept & ~full;
  assign pop      = ~empty & ready_i;

  fwft_ram_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (pipe_data_i),
    .pop_i   (ready_i),
    .data_o  (data_o),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  always_comb begin
    inflight_nxt = inflight;
    if (fire & ~accept) begin
      inflight_nxt = inflight + CNT_W'(1);
    end else if (~fire & accept) begin
      inflight_nxt = inflight - CNT_W'(1);
    end

    count_nxt = count;
    if (push_ok & ~pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (~push_ok & pop) begin
      count_nxt = count - CNT_W'(1);
    end

    occupancy_nxt = {1'b0, count_nxt} + {1'b0, inflight_nxt};
  end

  // Launch permission is registered from the next-state occupancy, which
  // equals (count + inflight) < DEPTH every cycle after reset, has no input
  // path, and lets the async reset hold it low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight   <= '0;
      issue_ok_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight   <= inflight_nxt;
      issue_ok_q <= (occupancy_nxt < (CNT_W + 1)'(DEPTH));
      err_q      <= err_q | spurious | overflow;
    end
  end

  assign issue_ok_o = issue_ok_q;
  assign valid_o    = ~empty;
  assign count_o    = count;
  assign inflight_o = inflight;
  assign err_o      = err_q;

endmodule

// File: tb/tb_credit_return_buffer.sv
// Directed bench for credit_return_buffer: pipeline model is a delay chain of
// PIPE_LATENCY cycles carrying launch tags; a queue of launched tags checks
// output order on every pop.
module tb_credit_return_buffer;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_req_i;
  logic        issue_ok_o;
  logic        pipe_valid_i;
  logic [15:0] pipe_data_i;
  logic        valid_o;
  logic [15:0] data_o;
  logic        ready_i;
  logic [3:0]  count_o;
  logic [3:0]  inflight_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  int fires  = 0;
  int pops   = 0;
  int f0;
  int p0;

  logic        vchain [LAT];
  logic [15:0] dchain [LAT];
  logic [15:0] launch_data;
  logic [15:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  credit_return_buffer #(
    .DATA_WIDTH   (16),
    .PIPE_LATENCY (LAT),
    .DEPTH        (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_req_i  (issue_req_i),
    .issue_ok_o   (issue_ok_o),
    .pipe_valid_i (pipe_valid_i),
    .pipe_data_i  (pipe_data_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .inflight_o   (inflight_o),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record launch/pop before the edge, then advance the pipe model.
  task automatic tick();
    logic        f;
    logic        p;
    logic [15:0] d;
    logic [15:0] pd;
    f  = issue_req_i & issue_ok_o;
    d  = launch_data;
    p  = valid_o & ready_i;
    pd = data_o;
    if (f) begin
      exp_q.push_back(d);
      launch_data = launch_data + 16'd1;
      fires++;
    end
    if (p) begin
      pops++;
      if (exp_q.size() == 0) begin
        chk("pop_model_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("pop_order", 32'(pd), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk_i);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      vchain[i] = vchain[i-1];
      dchain[i] = dchain[i-1];
    end
    vchain[0]    = f;
    dchain[0]    = d;
    pipe_valid_i = vchain[LAT-1];
    pipe_data_i  = dchain[LAT-1];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    issue_req_i  = 1'b0;
    pipe_valid_i = 1'b0;
    pipe_data_i  = '0;
    ready_i      = 1'b0;
    launch_data  = '0;
    for (int i = 0; i < LAT; i++) begin
      vchain[i] = 1'b0;
      dchain[i] = '0;
    end

    // Reset state
    #3;
    chk("rst_issue_ok", 32'(issue_ok_o), 32'd0);
    chk("rst_valid",    32'(valid_o),    32'd0);
    chk("rst_data",     32'(data_o),     32'd0);
    chk("rst_count",    32'(count_o),    32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_err",      32'(err_o),      32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    chk("idle_issue_ok", 32'(issue_ok_o), 32'd1);

    // 1. Single item: launch c0, arrival c4, visible c5 only
    launch_data = 16'h1234;
    ready_i     = 1'b1;
    issue_req_i = 1'b1;
    tick();
    issue_req_i = 1'b0;
    chk("t1_inflight", 32'(inflight_o), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      chk("t1_valid", 32'(valid_o), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) chk("t1_data", 32'(data_o), 32'h1234);
    end
    chk("t1_count_end",    32'(count_o),    32'd0);
    chk("t1_inflight_end", 32'(inflight_o), 32'd0);

    // 2. Backpressure: exactly DEPTH fires, then permission drops
    ready_i     = 1'b0;
    issue_req_i = 1'b1;
    launch_data = 16'h0000;
    f0          = fires;
    for (int k = 0; k < 14; k++) begin
      chk("t2_issue_ok", 32'(issue_ok_o), (k < DEPTH) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t2_fires",    32'(fires - f0),  32'd8);
    chk("t2_count",    32'(count_o),     32'd8);
    chk("t2_inflight", 32'(inflight_o),  32'd0);
    chk("t2_err",      32'(err_o),       32'd0);
    chk("t2_ok_full",  32'(issue_ok_o),  32'd0);
    issue_req_i = 1'b0;
    ready_i     = 1'b1;
    chk("t2_head", 32'(data_o), 32'h0000);
    p0 = pops;
    repeat (8) tick();
    chk("t2_pops",       32'(pops - p0), 32'd8);
    chk("t2_drained",    32'(count_o),   32'd0);
    chk("t2_valid_low",  32'(valid_o),   32'd0);

    // 3. Streaming at one item per cycle
    launch_data = 16'h0100;
    f0          = fires;
    p0          = pops;
    issue_req_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      chk("t3_issue_ok",  32'(issue_ok_o),     32'd1);
      chk("t3_count_le1", 32'(count_o <= 4'd1), 32'd1);
      tick();
    end
    issue_req_i = 1'b0;
    repeat (6) tick();
    chk("t3_fires",    32'(fires - f0), 32'd100);
    chk("t3_pops",     32'(pops - p0),  32'd100);
    chk("t3_count",    32'(count_o),    32'd0);
    chk("t3_inflight", 32'(inflight_o), 32'd0);

    // 4. Credit return: one pop while full yields exactly one launch slot
    ready_i     = 1'b0;
    issue_req_i = 1'b1;
    launch_data = 16'h0200;
    repeat (20) tick();
    chk("t4_full_count", 32'(count_o),    32'd8);
    chk("t4_full_ok",    32'(issue_ok_o), 32'd0);
    f0 = fires;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("t4_ok_after_pop", 32'(issue_ok_o), 32'd1);
    chk("t4_count_7",      32'(count_o),    32'd7);
    tick();
    chk("t4_ok_one_cycle", 32'(issue_ok_o), 32'd0);
    chk("t4_inflight",     32'(inflight_o), 32'd1);
    chk("t4_one_fire",     32'(fires - f0), 32'd1);
    repeat (4) tick();
    chk("t4_refull_count",    32'(count_o),    32'd8);
    chk("t4_refull_inflight", 32'(inflight_o), 32'd0);
    chk("t4_refull_ok",       32'(issue_ok_o), 32'd0);
    issue_req_i = 1'b0;
    ready_i     = 1'b1;
    repeat (9) tick();
    chk("t4_drained",    32'(count_o),      32'd0);
    chk("t4_model_empty", 32'(exp_q.size()), 32'd0);

    // 5. Spurious arrival with nothing in flight
    chk("t5_err_before",      32'(err_o),      32'd0);
    chk("t5_inflight_before", 32'(inflight_o), 32'd0);
    pipe_valid_i = 1'b1;
    pipe_data_i  = 16'hDEAD;
    tick();
    chk("t5_err_set", 32'(err_o),   32'd1);
    chk("t5_count",   32'(count_o), 32'd0);
    chk("t5_valid",   32'(valid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_dead",   32'(data_o != 16'hDEAD), 32'd1);
      tick();
      chk("t5_err_sticky", 32'(err_o), 32'd1);
    end

    // 6. Reset mid-operation: 3 in flight, 2 buffered
    ready_i     = 1'b0;
    issue_req_i = 1'b1;
    launch_data = 16'h0300;
    repeat (5) tick();
    issue_req_i = 1'b0;
    tick();
    chk("t6_count_pre",    32'(count_o),    32'd2);
    chk("t6_inflight_pre", 32'(inflight_o), 32'd3);
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_issue_ok", 32'(issue_ok_o), 32'd0);
    chk("t6_rst_valid",    32'(valid_o),    32'd0);
    chk("t6_rst_data",     32'(data_o),     32'd0);
    chk("t6_rst_count",    32'(count_o),    32'd0);
    chk("t6_rst_inflight", 32'(inflight_o), 32'd0);
    chk("t6_rst_err",      32'(err_o),      32'd0);
    #1;
    rst_i = 1'b0;
    tick();
    chk("t6_stale_err",      32'(err_o),      32'd1);
    chk("t6_stale_count",    32'(count_o),    32'd0);
    chk("t6_stale_inflight", 32'(inflight_o), 32'd0);
    chk("t6_issue_ok_back",  32'(issue_ok_o), 32'd1);
    repeat (2) tick();
    chk("t6_end_count", 32'(count_o), 32'd0);
    chk("t6_end_valid", 32'(valid_o), 32'd0);
    chk("t6_end_err",   32'(err_o),   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
